acc_b_regs: RTL and testbench
=============================

Name: acc_b_regs

Overview:
- Holds the two ALU operands: the accumulator (A) and the B register.
- Drives them continuously into the downstream add/sub stage.
- Captures the add/sub result back into A on a write-back strobe, and updates the status flags (Z, N, C, V) at the same time.
- Loads both registers from the shared 8-bit bus, and drives A onto the bus when enabled.

Parameters:
- WIDTH, 8, datapath width of A, B, bus and result.

Ports:
- clk_i  input  1  system clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- bus_i  input  WIDTH  shared bus value, source for loads.
- la_i  input  1  load A from bus_i.
- lb_i  input  1  load B from bus_i.
- ea_i  input  1  drive A onto bus_o.
- wa_i  input  1  write back alu_res_i into A and update flags.
- sub_en_i  input  1  current ALU mode (1 = A-B); used for flag computation.
- alu_res_i  input  WIDTH  result returned by the add/sub stage.
- a_o  output  WIDTH  A register contents to the ALU.
- b_o  output  WIDTH  B register contents to the ALU.
- bus_o  output  WIDTH  A when ea_i=1, else all zeros.
- bus_oe_o  output  1  equals ea_i; bus arbiter qualifier.
- flag_z_o  output  1  zero flag.
- flag_n_o  output  1  negative flag (MSB of last written result).
- flag_c_o  output  1  carry flag.
- flag_v_o  output  1  signed overflow flag.
- wb_done_o  output  1  one-cycle pulse, the cycle after a write-back.
- err_o  output  1  sticky conflict error.

Behaviour:
- Reset is synchronous: on a clk_i edge with rst_i=1, all registered outputs clear to 0 (A, B, all four flags, wb_done_o, err_o). rst_i overrides every other input.
- A update priority per edge: rst_i > wa_i > la_i > hold.
  - wa_i=1: A <= alu_res_i.
  - Else la_i=1: A <= bus_i.
- B update: lb_i=1 gives B <= bus_i; otherwise hold. lb_i is independent of the A strobes. la_i and lb_i together load the same bus value into both registers.
- Conflict: la_i=1 and wa_i=1 on the same edge is illegal.
  - wa_i still wins.
  - err_o is set and stays 1 until rst_i.
- Flags update only on an edge with wa_i=1 and are held otherwise. la_i does not touch the flags. Each flag is computed from the pre-edge A/B values (a_q, b_q), alu_res_i and sub_en_i:
  - Z = (alu_res_i == 0).
  - N = alu_res_i[WIDTH-1].
  - C, add mode: carry-out of the (WIDTH+1)-bit sum a_q+b_q.
  - C, sub mode: 1 when a_q >= b_q unsigned (no borrow).
  - V, add mode: a_q and b_q have the same MSB and the result MSB differs from it.
  - V, sub mode: a_q and b_q have different MSBs and the result MSB differs from a_q's MSB.
- Flags are computed internally and do not trust alu_res_i for carry. alu_res_i is still used for Z and N.
- Timing:
  - a_o and b_o are the register outputs directly, so a new value is visible the cycle after the load edge.
  - Operand-to-result latency through the downstream stage is combinational, so wa_i may be asserted one cycle after the operand load.
- wb_done_o = registered wa_i: it is high for exactly one cycle after each write-back edge. Back-to-back wa_i gives continuous high.
- bus_o and bus_oe_o are combinational from ea_i and the A register. ea_i with la_i on the same edge is allowed: bus_o shows the old A, and A captures bus_i at the edge.
- Wrap-around: arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- Reset: drive random inputs, then rst_i=1 for 1 edge -> A=B=0, all flags 0, err_o=0, wb_done_o=0. Also assert rst_i together with la_i=1, bus_i=0x55 -> A stays 0.
- Load/add: la_i with bus_i=0x28, then lb_i with bus_i=0x0E, sub_en_i=0, alu_res_i=0x36, wa_i -> A=0x36, Z=0, N=0, C=0, V=0, wb_done_o high for 1 cycle.
- Add carry/overflow:
  - A=0xFF, B=0x01, alu_res_i=0x00, wa_i -> A=0x00, Z=1, C=1, V=0.
  - A=0x7F, B=0x01, alu_res_i=0x80 -> N=1, V=1, C=0.
- Subtract:
  - A=0x05, B=0x07, sub_en_i=1, alu_res_i=0xFE -> A=0xFE, C=0, N=1, V=0.
  - A=0x80, B=0x01, alu_res_i=0x7F -> V=1, C=1.
- Conflict: la_i=1, wa_i=1, bus_i=0xAA, alu_res_i=0x11 -> A=0x11, err_o=1, and it remains 1 across 10 idle cycles until rst_i.
- Bus drive and flag hold:
  - ea_i=1 with A=0x3C -> bus_o=0x3C, bus_oe_o=1.
  - ea_i=0 -> bus_o=0x00.
  - la_i of 0x00 -> Z flag unchanged.

Source files
------------

// File: rtl/acc_b_regs_if.sv
// Operand-register port bundle: bus loads, write-back strobe and ALU result in; operands, bus drive, flags and status out.
// The controller/sequencer side uses the master modport, the register block uses the slave modport.
interface acc_b_regs_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] bus_i;
  logic             la_i;
  logic             lb_i;
  logic             ea_i;
  logic             wa_i;
  logic             sub_en_i;
  logic [WIDTH-1:0] alu_res_i;

  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic [WIDTH-1:0] bus_o;
  logic             bus_oe_o;
  logic             flag_z_o;
  logic             flag_n_o;
  logic             flag_c_o;
  logic             flag_v_o;
  logic             wb_done_o;
  logic             err_o;

  modport master (
    output bus_i, la_i, lb_i, ea_i, wa_i, sub_en_i, alu_res_i,
    input  a_o, b_o, bus_o, bus_oe_o,
    input  flag_z_o, flag_n_o, flag_c_o, flag_v_o, wb_done_o, err_o
  );

  modport slave (
    input  bus_i, la_i, lb_i, ea_i, wa_i, sub_en_i, alu_res_i,
    output a_o, b_o, bus_o, bus_oe_o,
    output flag_z_o, flag_n_o, flag_c_o, flag_v_o, wb_done_o, err_o
  );
endinterface

// File: rtl/acc_b_regs.sv
// Accumulator A and B operand registers with write-back capture and Z/N/C/V flags.
// Loads and write-back land one edge after the strobe; bus drive is combinational; no backpressure.
module acc_b_regs #(
  parameter int WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  acc_b_regs_if.slave io
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;
  logic             r_wb_done;
  logic             r_err;

  logic             w_a_msb;
  logic             w_b_msb;
  logic             w_res_msb;
  logic             w_add_c;
  logic             w_sub_c;
  logic             w_add_v;
  logic             w_sub_v;
  logic             w_c;
  logic             w_v;
  logic             w_z;
  logic             w_conflict;

  assign w_a_msb   = r_a[WIDTH-1];
  assign w_b_msb   = r_b[WIDTH-1];
  assign w_res_msb = io.alu_res_i[WIDTH-1];

  // a+b overflows 2^WIDTH exactly when b exceeds the headroom left above a, which is ~a.
  assign w_add_c = (r_b > ~r_a);
  assign w_sub_c = (r_a >= r_b);

  assign w_add_v = (w_a_msb == w_b_msb) && (w_res_msb != w_a_msb);
  assign w_sub_v = (w_a_msb != w_b_msb) && (w_res_msb != w_a_msb);

  assign w_c = io.sub_en_i ? w_sub_c : w_add_c;
  assign w_v = io.sub_en_i ? w_sub_v : w_add_v;
  assign w_z = (io.alu_res_i == '0);

  assign w_conflict = io.la_i && io.wa_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a       <= '0;
      r_b       <= '0;
      r_z       <= 1'b0;
      r_n       <= 1'b0;
      r_c       <= 1'b0;
      r_v       <= 1'b0;
      r_wb_done <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // Write-back beats a bus load when both are strobed; the clash is flagged below.
      if (io.wa_i) begin
        r_a <= io.alu_res_i;
        r_z <= w_z;
        r_n <= w_res_msb;
        r_c <= w_c;
        r_v <= w_v;
      end else if (io.la_i) begin
        r_a <= io.bus_i;
      end

      if (io.lb_i) begin
        r_b <= io.bus_i;
      end

      r_wb_done <= io.wa_i;

      if (w_conflict) begin
        r_err <= 1'b1;
      end
    end
  end

  assign io.a_o       = r_a;
  assign io.b_o       = r_b;
  assign io.bus_o     = io.ea_i ? r_a : '0;
  assign io.bus_oe_o  = io.ea_i;
  assign io.flag_z_o  = r_z;
  assign io.flag_n_o  = r_n;
  assign io.flag_c_o  = r_c;
  assign io.flag_v_o  = r_v;
  assign io.wb_done_o = r_wb_done;
  assign io.err_o     = r_err;

endmodule

// File: tb/tb_acc_b_regs.sv
// Bench for acc_b_regs: vector table of load/write-back cases checked through a write-back scoreboard,
// plus hand sequences for reset, conflict, bus drive, flag hold and back-to-back write-back.
module tb_acc_b_regs;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  acc_b_regs_if #(.WIDTH(W)) u_if ();

  acc_b_regs #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (u_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    u_if.bus_i     = '0;
    u_if.la_i      = 1'b0;
    u_if.lb_i      = 1'b0;
    u_if.ea_i      = 1'b0;
    u_if.wa_i      = 1'b0;
    u_if.sub_en_i  = 1'b0;
    u_if.alu_res_i = '0;
  endtask

  task automatic load_a(input logic [W-1:0] v);
    u_if.la_i  = 1'b1;
    u_if.bus_i = v;
    step();
    u_if.la_i  = 1'b0;
  endtask

  task automatic load_b(input logic [W-1:0] v);
    u_if.lb_i  = 1'b1;
    u_if.bus_i = v;
    step();
    u_if.lb_i  = 1'b0;
  endtask

  task automatic write_back(input logic [W-1:0] res, input logic sub, input exp_t e);
    u_if.wa_i      = 1'b1;
    u_if.sub_en_i  = sub;
    u_if.alu_res_i = res;
    q.push_back(e);
    step();
    u_if.wa_i      = 1'b0;
  endtask

  // Scoreboard: every wb_done pulse must match the oldest pending write-back expectation.
  always @(negedge clk) begin
    if (mon_en && u_if.wb_done_o === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got wb_done=1 expected no pending write-back");
      end else begin
        mon_e = q.pop_front();
        chk("wb_a", u_if.a_o, mon_e.a);
        chk("wb_z", u_if.flag_z_o, mon_e.z);
        chk("wb_n", u_if.flag_n_o, mon_e.n);
        chk("wb_c", u_if.flag_c_o, mon_e.c);
        chk("wb_v", u_if.flag_v_o, mon_e.v);
      end
    end
  end

  initial begin
    //           a      b      sub   res    z  n  c  v
    vecs[0] = '{8'h28, 8'h0E, 1'b0, 8'h36, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0};

    clear_inputs();

    // Random traffic, then a reset edge with random inputs still applied.
    for (int i = 0; i < 20; i++) begin
      u_if.bus_i     = W'($urandom);
      u_if.la_i      = 1'($urandom);
      u_if.lb_i      = 1'($urandom);
      u_if.ea_i      = 1'($urandom);
      u_if.wa_i      = 1'($urandom);
      u_if.sub_en_i  = 1'($urandom);
      u_if.alu_res_i = W'($urandom);
      step();
    end
    u_if.la_i = 1'b1;
    u_if.wa_i = 1'b1;
    u_if.bus_i = 8'hA5;
    u_if.alu_res_i = 8'h5A;
    rst = 1'b1;
    step();
    chk("rst_a", u_if.a_o, 8'h00);
    chk("rst_b", u_if.b_o, 8'h00);
    chk("rst_flags", {u_if.flag_z_o, u_if.flag_n_o, u_if.flag_c_o, u_if.flag_v_o}, 4'b0000);
    chk("rst_err", u_if.err_o, 1'b0);
    chk("rst_wb_done", u_if.wb_done_o, 1'b0);

    clear_inputs();
    u_if.la_i  = 1'b1;
    u_if.bus_i = 8'h55;
    step();
    chk("rst_over_la", u_if.a_o, 8'h00);
    rst = 1'b0;
    clear_inputs();
    step();

    mon_en = 1'b1;

    // Table: operands loaded, then write-back one cycle later; equal operands use a joint la+lb load.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].a == vecs[i].b) begin
        u_if.la_i  = 1'b1;
        u_if.lb_i  = 1'b1;
        u_if.bus_i = vecs[i].a;
        step();
        u_if.la_i  = 1'b0;
        u_if.lb_i  = 1'b0;
        chk("joint_load_a", u_if.a_o, vecs[i].a);
        chk("joint_load_b", u_if.b_o, vecs[i].b);
      end else begin
        load_a(vecs[i].a);
        load_b(vecs[i].b);
        chk("load_b_holds_a", u_if.a_o, vecs[i].a);
      end
      write_back(vecs[i].res, vecs[i].sub,
                 '{vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v});
      chk("wb_done_high", u_if.wb_done_o, 1'b1);
    end
    step();
    chk("wb_done_low", u_if.wb_done_o, 1'b0);

    // A bus load must leave the flags from the last write-back (Z=0 N=1 C=1 V=0) untouched.
    load_a(8'h00);
    chk("hold_a", u_if.a_o, 8'h00);
    chk("hold_flags", {u_if.flag_z_o, u_if.flag_n_o, u_if.flag_c_o, u_if.flag_v_o}, 4'b0110);

    // Back-to-back write-back: second uses A from the first.
    load_a(8'h01);
    load_b(8'h01);
    u_if.wa_i = 1'b1;
    u_if.sub_en_i = 1'b0;
    u_if.alu_res_i = 8'h02;
    q.push_back('{8'h02, 1'b0, 1'b0, 1'b0, 1'b0});
    step();
    u_if.alu_res_i = 8'h03;
    q.push_back('{8'h03, 1'b0, 1'b0, 1'b0, 1'b0});
    step();
    u_if.wa_i = 1'b0;
    chk("b2b_wb_done", u_if.wb_done_o, 1'b1);
    step();
    chk("b2b_wb_done_end", u_if.wb_done_o, 1'b0);

    // Bus drive, including ea with la on the same edge.
    load_a(8'h3C);
    u_if.ea_i = 1'b1;
    #1;
    chk("bus_drive", u_if.bus_o, 8'h3C);
    chk("bus_oe", u_if.bus_oe_o, 1'b1);
    u_if.la_i  = 1'b1;
    u_if.bus_i = 8'h99;
    #1;
    chk("bus_old_a", u_if.bus_o, 8'h3C);
    step();
    u_if.la_i = 1'b0;
    chk("bus_new_a", u_if.bus_o, 8'h99);
    u_if.ea_i = 1'b0;
    #1;
    chk("bus_off", u_if.bus_o, 8'h00);
    chk("bus_oe_off", u_if.bus_oe_o, 1'b0);

    // Conflict: A=01 B=10 add, write-back wins over la and err latches.
    load_a(8'h01);
    load_b(8'h10);
    chk("pre_conflict_err", u_if.err_o, 1'b0);
    u_if.la_i  = 1'b1;
    u_if.bus_i = 8'hAA;
    write_back(8'h11, 1'b0, '{8'h11, 1'b0, 1'b0, 1'b0, 1'b0});
    u_if.la_i  = 1'b0;
    chk("conflict_a", u_if.a_o, 8'h11);
    chk("conflict_err", u_if.err_o, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("err_sticky", u_if.err_o, 1'b1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_cleared", u_if.err_o, 1'b0);

    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    chk("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
